// File: rtl/rvm_pkg.sv
// Shared definitions for the riscv-mini program driver.
//  - Opcode field values of the 16-bit mini-CPU instruction word (bits [1:0]).
//  - Default idle/stall instruction.
//  - Driver FSM state encoding.
//  - Helper that classifies output-type instructions.
package rvm_pkg;

  localparam logic [1:0] OP_R   = 2'b00;
  localparam logic [1:0] OP_I   = 2'b01;
  localparam logic [1:0] OP_L   = 2'b10;
  localparam logic [1:0] OP_OUT = 2'b11;

  // opcode 11, funct3 000: drives uo_out but never writes a register
  localparam logic [15:0] NOP_INSTR = 16'h0003;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_RUN   = 2'b01,
    ST_FLUSH = 2'b10,
    ST_DONE  = 2'b11
  } state_e;

  // True when the instruction makes the CPU present a result on uo_out
  function automatic logic is_out(input logic [15:0] instr);
    return (instr[1:0] == OP_OUT);
  endfunction

endpackage

// File: rtl/rvm_sync_fifo.sv
// Synchronous FIFO holding captured CPU results.
// Ports:
//  clk, rst_n     clock / async active-low reset
//  push, push_data  write request and data
//  pop, pop_data    read request and head-of-queue data
//  count, full, empty  occupancy status
module rvm_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           pop_data,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push_s, do_pop_s;

  assign full     = (count_q == CW'(DEPTH));
  assign empty    = (count_q == {CW{1'b0}});
  assign count    = count_q;
  assign pop_data = mem_q[rd_q];

  // Qualify requests and compute next pointers / occupancy
  always_comb begin
    do_push_s = push && (!full || pop);
    do_pop_s  = pop && !empty;
    wr_d      = wr_q;
    rd_d      = rd_q;
    count_d   = count_q;
    if (do_push_s) begin
      wr_d = wr_q + AW'(1);
    end else begin
      wr_d = wr_q;
    end
    if (do_pop_s) begin
      rd_d = rd_q + AW'(1);
    end else begin
      rd_d = rd_q;
    end
    case ({do_push_s, do_pop_s})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointer and occupancy registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q    <= {AW{1'b0}};
      rd_q    <= {AW{1'b0}};
      count_q <= {CW{1'b0}};
    end else begin
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      count_q <= count_d;
    end
  end

  // Storage array, written only on an accepted push
  always_ff @(posedge clk) begin
    if (do_push_s) begin
      mem_q[wr_q] <= push_data;
    end
  end

endmodule

// File: rtl/rvm_program_driver.sv
// Host-side driver for the tt_um_riscv_mini pin interface.
// Buffers a program of 16-bit instructions, issues one per clock on instr_out
// (ui_in = instr_out[7:0], uio_in = instr_out[15:8]) and captures uo_out for
// every output-type instruction into a result FIFO.
// Ports:
//  prog_valid/prog_ready/prog_data  program load handshake (IDLE only)
//  prog_clr, start                  clear program / run program (IDLE only)
//  busy, done                       run status; done is a one-cycle pulse
//  instr_out, cpu_result            instruction to CPU / its uo_out
//  res_valid/res_ready/res_data     result FIFO handshake
module rvm_program_driver #(
  parameter int          PROG_DEPTH = 16,
  parameter int          RES_DEPTH  = 4,
  parameter logic [15:0] NOP_INSTR  = rvm_pkg::NOP_INSTR
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        prog_valid,
  output logic        prog_ready,
  input  logic [15:0] prog_data,
  input  logic        prog_clr,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic [15:0] instr_out,
  input  logic [7:0]  cpu_result,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [7:0]  res_data
);

  import rvm_pkg::*;

  localparam int AW = $clog2(PROG_DEPTH);
  localparam int PW = AW + 1;
  localparam int CW = $clog2(RES_DEPTH) + 1;

  logic [15:0]   mem_q [PROG_DEPTH];
  state_e        state_q, state_d;
  logic [PW-1:0] pc_q, pc_d, len_q, len_d, pc_inc_s;
  logic [15:0]   instr_q, instr_d, cand_s;
  logic          pend_q, pend_d;
  logic          load_s, prog_ready_s, fifo_empty_s, fifo_full_s;
  logic [CW-1:0] fifo_count_s;
  logic [CW:0]   occ_s;

  assign prog_ready_s = (state_q == ST_IDLE) && (len_q < PW'(PROG_DEPTH));
  assign prog_ready   = prog_ready_s;
  assign busy         = (state_q == ST_RUN) || (state_q == ST_FLUSH);
  assign done         = (state_q == ST_DONE);
  assign instr_out    = instr_q;
  assign res_valid    = !fifo_empty_s;

  assign cand_s   = mem_q[pc_q[AW-1:0]];
  assign pc_inc_s = pc_q + PW'(1);
  // Slots already claimed: stored results plus the capture due at this edge
  assign occ_s    = {1'b0, fifo_count_s} + {{CW{1'b0}}, pend_q};

  // Next-state, issue selection and program-length bookkeeping
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    len_d   = len_q;
    instr_d = NOP_INSTR;
    pend_d  = 1'b0;
    load_s  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (prog_clr) begin
          len_d = {PW{1'b0}};
        end else if (start) begin
          pc_d    = {PW{1'b0}};
          state_d = (len_q == {PW{1'b0}}) ? ST_DONE : ST_RUN;
        end else if (prog_valid && prog_ready_s) begin
          load_s = 1'b1;
          len_d  = len_q + PW'(1);
        end else begin
          len_d = len_q;
        end
      end
      ST_RUN: begin
        // Stall an output instruction whose result could not be stored;
        // the NOP carries no pending capture, so nothing is duplicated.
        if (is_out(cand_s) && (occ_s == (CW+1)'(RES_DEPTH))) begin
          instr_d = NOP_INSTR;
          pend_d  = 1'b0;
        end else begin
          instr_d = cand_s;
          pend_d  = is_out(cand_s);
          pc_d    = pc_inc_s;
          if (pc_inc_s == len_q) begin
            state_d = ST_FLUSH;
          end else begin
            state_d = ST_RUN;
          end
        end
      end
      ST_FLUSH: state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // FSM, counters and the registered instruction output
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      pc_q    <= {PW{1'b0}};
      len_q   <= {PW{1'b0}};
      instr_q <= NOP_INSTR;
      pend_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      len_q   <= len_d;
      instr_q <= instr_d;
      pend_q  <= pend_d;
    end
  end

  // Program buffer; contents survive runs so start can replay them
  always_ff @(posedge clk) begin
    if (load_s) begin
      mem_q[len_q[AW-1:0]] <= prog_data;
    end
  end

  rvm_sync_fifo #(
    .WIDTH (8),
    .DEPTH (RES_DEPTH)
  ) u_res_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (pend_q),
    .push_data (cpu_result),
    .pop       (res_ready),
    .pop_data  (res_data),
    .count     (fifo_count_s),
    .full      (fifo_full_s),
    .empty     (fifo_empty_s)
  );

endmodule
